// File: rtl/regbus_arbiter_pkg.sv
// Shared types and helpers for the register-bus arbiter (package regbus_pkg).
package regbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_AW = 2;
    localparam int DEF_DW = 32;

    function automatic int rr_next(input int idx, input int n);
        return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
    endfunction

endpackage

// File: rtl/regbus_arbiter_if.sv
// Requester-side and target-side signals of the register-bus arbiter.
interface regbus_arbiter_if
    import regbus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) ();

    logic [NREQ-1:0]    i_req;
    logic [NREQ-1:0]    i_we;
    logic [NREQ*AW-1:0] i_addr;
    logic [NREQ*DW-1:0] i_wdata;
    logic [NREQ-1:0]    o_ack;
    logic [DW-1:0]      o_rdata;
    logic               o_busy;
    logic [AW-1:0]      o_rreg;
    logic [AW-1:0]      o_wreg;
    logic               o_rd;
    logic               o_wr;
    logic [DW-1:0]      o_wdata;
    logic [DW-1:0]      i_rdata;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_rdata,
        output o_ack, o_rdata, o_busy, o_rreg, o_wreg, o_rd, o_wr, o_wdata
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_rdata,
        input  o_ack, o_rdata, o_busy, o_rreg, o_wreg, o_rd, o_wr, o_wdata
    );

endinterface

// File: rtl/regbus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_picker
    import regbus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic            o_valid,
    output logic [IW-1:0]   o_winner
);

    logic [IW-1:0] w_idx;
    logic          w_hit;

    // Walk the ring once starting just after the last grant.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = i_last;
        w_hit    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx    = IW'(rr_next(int'(w_idx), NREQ));
            w_hit    = !o_valid && i_req[w_idx];
            o_winner = w_hit ? w_idx : o_winner;
            o_valid  = o_valid | i_req[w_idx];
        end
    end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing one register-bus target between NREQ requesters.
// Optional macro REGBUS_ARB_PRIO_EN gives requester 0 fixed highest priority.
module regbus_arbiter
    import regbus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input logic             clk,
    input logic             rst_n,
    regbus_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_win;
    logic            r_we;

    logic [NREQ-1:0] w_pick_req;
    logic            w_pick_valid;
    logic [IW-1:0]   w_pick_idx;
    logic            w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic            w_upd_last;
    logic            w_load;
    logic            w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_rd_nxt;
    logic            w_wr_nxt;
    logic [NREQ-1:0] w_ack_nxt;
    logic            w_busy_nxt;
    logic [DW-1:0]   w_rdata_nxt;
    logic [AW-1:0]   w_rreg_nxt;
    logic [AW-1:0]   w_wreg_nxt;
    logic [DW-1:0]   w_wdata_nxt;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_picker (
        .i_req    (w_pick_req),
        .i_last   (r_last),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_idx)
    );

`ifdef REGBUS_ARB_PRIO_EN
    // Requester 0 bypasses the ring and never moves the pointer.
    always_comb begin
        w_pick_req    = bus.i_req;
        w_pick_req[0] = 1'b0;
        w_grant       = bus.i_req[0] | w_pick_valid;
        w_grant_idx   = bus.i_req[0] ? '0 : w_pick_idx;
        w_upd_last    = ~bus.i_req[0];
    end
`else
    // Pure round-robin over all requesters.
    always_comb begin
        w_pick_req  = bus.i_req;
        w_grant     = w_pick_valid;
        w_grant_idx = w_pick_idx;
        w_upd_last  = 1'b1;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE waits for a grant, ISSUE and RESP last one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_grant ? ISSUE : IDLE;
            ISSUE:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Winner, direction and round-robin pointer captured at grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= IW'(NREQ - 1);
            r_win  <= '0;
            r_we   <= 1'b0;
        end else if ((r_state == IDLE) && w_grant) begin
            r_win <= w_grant_idx;
            r_we  <= bus.i_we[w_grant_idx];
            if (w_upd_last) begin
                r_last <= w_grant_idx;
            end
        end
    end

    // Output next-values; address/data registers only move with their strobe.
    always_comb begin
        w_load      = (r_state == IDLE) && w_grant;
        w_sel_we    = bus.i_we[w_grant_idx];
        w_sel_addr  = bus.i_addr[w_grant_idx * AW +: AW];
        w_sel_wdata = bus.i_wdata[w_grant_idx * DW +: DW];
        w_rd_nxt    = w_load && !w_sel_we;
        w_wr_nxt    = w_load && w_sel_we;
        w_ack_nxt   = (r_state == ISSUE) ? (NREQ'(1'b1) << r_win) : '0;
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_rdata_nxt = ((r_state == ISSUE) && !r_we) ? bus.i_rdata : bus.o_rdata;
        w_rreg_nxt  = w_rd_nxt ? w_sel_addr : bus.o_rreg;
        w_wreg_nxt  = w_wr_nxt ? w_sel_addr : bus.o_wreg;
        w_wdata_nxt = w_wr_nxt ? w_sel_wdata : bus.o_wdata;
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.o_ack   <= '0;
            bus.o_rdata <= '0;
            bus.o_busy  <= 1'b0;
            bus.o_rreg  <= '0;
            bus.o_wreg  <= '0;
            bus.o_rd    <= 1'b0;
            bus.o_wr    <= 1'b0;
            bus.o_wdata <= '0;
        end else begin
            bus.o_ack   <= w_ack_nxt;
            bus.o_rdata <= w_rdata_nxt;
            bus.o_busy  <= w_busy_nxt;
            bus.o_rreg  <= w_rreg_nxt;
            bus.o_wreg  <= w_wreg_nxt;
            bus.o_rd    <= w_rd_nxt;
            bus.o_wr    <= w_wr_nxt;
            bus.o_wdata <= w_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-schedule model of the arbiter and the register target.
module tb_regbus_arbiter;
    import regbus_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 2;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_v;
    always #5 clk = ~clk;

    regbus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    regbus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Target register block: preset contents until first written.
    logic [DW-1:0] tgt_regs [4];
    bit            tgt_vld  [4];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] idx);
        return 32'h1234_5675 + DW'(idx);
    endfunction

    assign bus.i_rdata = tgt_vld[bus.o_rreg] ? tgt_regs[bus.o_rreg] : init_val(bus.o_rreg);

    always @(posedge clk) begin
        if (bus.o_wr) begin
            tgt_regs[bus.o_wreg] <= bus.o_wdata;
            tgt_vld[bus.o_wreg]  <= 1'b1;
        end
    end

    // Requester agents.
    logic [NREQ-1:0] act = '0;
    logic            rwe   [NREQ];
    logic [AW-1:0]   raddr [NREQ];
    logic [DW-1:0]   rwd   [NREQ];
    logic [NREQ-1:0] ack_seen = '0;

    // Reference model: schedule of the current transaction plus target image.
    int            cyc = 0;
    bit            m_valid = 1'b0;
    int            m_zero_cyc = -10;
    int            m_issue = -10;
    int            m_ack = -10;
    int            m_free = 0;
    int            m_ptr = NREQ - 1;
    int            m_win = 0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_last_rdata = '0;
    logic [DW-1:0] m_regs [4];

    int n_checks = 0;
    int n_fail = 0;
    int ack_log[$];
    int ack_cyc[$];
    int strobe_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef REGBUS_ARB_PRIO_EN
        if (r[0]) return 0;
        r[0] = 1'b0;
`endif
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic arm(input int k);
        rwe[k]   = 1'($urandom_range(0, 1));
        raddr[k] = AW'($urandom_range(0, 3));
        rwd[k]   = $urandom;
    endtask

    // Requesters that saw ack either drop or start a fresh transaction.
    task automatic react(input logic [NREQ-1:0] keep);
        for (int k = 0; k < NREQ; k++) begin
            if (ack_seen[k]) begin
                act[k] = keep[k];
                arm(k);
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            bus.i_req[k]             = act[k];
            bus.i_we[k]              = rwe[k];
            bus.i_addr[k*AW +: AW]   = raddr[k];
            bus.i_wdata[k*DW +: DW]  = rwd[k];
        end
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] e_ack;
        bit e_rd, e_wr;
        if (!m_valid) return;
        if (cyc == m_zero_cyc) begin
            check_eq("rst_ack",   bus.o_ack,   '0);
            check_eq("rst_rd",    bus.o_rd,    1'b0);
            check_eq("rst_wr",    bus.o_wr,    1'b0);
            check_eq("rst_busy",  bus.o_busy,  1'b0);
            check_eq("rst_rdata", bus.o_rdata, '0);
            check_eq("rst_regs",  {bus.o_rreg, bus.o_wreg, bus.o_wdata}, '0);
            return;
        end
        e_rd  = (cyc == m_issue) && !m_we;
        e_wr  = (cyc == m_issue) && m_we;
        e_ack = (cyc == m_ack) ? (NREQ'(1'b1) << m_win) : '0;
        if ((cyc == m_ack) && !m_we) m_last_rdata = m_rd;
        check_eq("ack",   bus.o_ack,   e_ack);
        check_eq("rd",    bus.o_rd,    e_rd);
        check_eq("wr",    bus.o_wr,    e_wr);
        check_eq("busy",  bus.o_busy,  (cyc == m_issue) || (cyc == m_ack));
        check_eq("rdata", bus.o_rdata, m_last_rdata);
        if (e_rd) check_eq("rreg", bus.o_rreg, m_addr);
        if (e_wr) begin
            check_eq("wreg",  bus.o_wreg,  m_addr);
            check_eq("wdata", bus.o_wdata, m_wd);
        end
    endtask

    task automatic model_update();
        int w;
        if (!rst_v) begin
            m_valid = 1'b1; m_zero_cyc = cyc + 1; m_issue = -10; m_ack = -10;
            m_free = cyc + 1; m_ptr = NREQ - 1; m_last_rdata = '0;
            return;
        end
        if (!m_valid || (cyc < m_free) || (act == '0)) return;
        w = model_pick(act, m_ptr);
`ifdef REGBUS_ARB_PRIO_EN
        if (w != 0) m_ptr = w;
`else
        m_ptr = w;
`endif
        m_win = w; m_we = rwe[w]; m_addr = raddr[w];
        if (rwe[w]) begin
            m_regs[raddr[w]] = rwd[w];
            m_wd = rwd[w];
        end else begin
            m_rd = m_regs[raddr[w]];
        end
        m_issue = cyc + 1; m_ack = cyc + 2; m_free = cyc + 3;
    endtask

    // One clock: drive after the edge, check at the falling edge.
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        rst_n = rst_v;
        drive();
        @(negedge clk);
        check_cycle();
        model_update();
        ack_seen = bus.o_ack;
        for (int k = 0; k < NREQ; k++) begin
            if (bus.o_ack[k]) begin
                ack_log.push_back(k);
                ack_cyc.push_back(cyc);
            end
        end
        if (bus.o_rd || bus.o_wr) strobe_cyc.push_back(cyc);
    endtask

    task automatic check_grants(input string tag, input int exp_q[$]);
        int got;
        check_eq({tag, "_count"}, ack_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < ack_log.size()) ? ack_log[i] : -1;
            check_eq(tag, got, exp_q[i]);
        end
    endtask

    task automatic clear_logs();
        ack_log.delete(); ack_cyc.delete(); strobe_cyc.delete();
    endtask

    initial begin
        logic [NREQ-1:0] keep;
        for (int i = 0; i < 4; i++) m_regs[i] = init_val(AW'(i));
        for (int k = 0; k < NREQ; k++) arm(k);
        rst_v = 1'b0; rst_n = 1'b0;
        drive();

        // Reset, then a single write from requester 0.
        step(); step();
        check_eq("reset_busy", bus.o_busy, 1'b0);
        check_eq("reset_ack",  bus.o_ack,  '0);
        rst_v = 1'b1;
        act[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 2'd2; rwd[0] = 32'hDEAD_BEEF;
        step();
        step();
        check_eq("wr_strobe", bus.o_wr,    1'b1);
        check_eq("wr_reg",    bus.o_wreg,  2'd2);
        check_eq("wr_data",   bus.o_wdata, 32'hDEAD_BEEF);
        step();
        check_eq("wr_ack",    bus.o_ack,   3'b001);
        react('0);

        // Read of index 3 by requester 1.
        act[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 2'd3;
        step();
        step();
        check_eq("rd_strobe", bus.o_rd,   1'b1);
        check_eq("rd_reg",    bus.o_rreg, 2'd3);
        step();
        check_eq("rd_ack",    bus.o_ack,   3'b010);
        check_eq("rd_data",   bus.o_rdata, 32'h1234_5678);
        react('0);

        // Contention between requesters 0 and 1.
        clear_logs();
        act[0] = 1'b1; act[1] = 1'b1; arm(0); arm(1);
        for (int n = 0; n < 12; n++) begin
            step();
            react(3'b011);
        end
        act = '0;
        check_grants("cont_grant", '{0, 1, 0, 1});
        for (int i = 1; i < ack_cyc.size(); i++) check_eq("cont_gap", ack_cyc[i] - ack_cyc[i-1], 3);

        // Back-to-back: requester 0 keeps requesting across its ack.
        clear_logs();
        act[0] = 1'b1; arm(0);
        for (int n = 0; n < 6; n++) begin
            step();
            react(3'b001);
        end
        act = '0;
        check_grants("b2b_grant", '{0, 0});
        check_eq("b2b_gap", (strobe_cyc.size() > 1) ? strobe_cyc[1] - strobe_cyc[0] : -1, 3);

        // Reset asserted during ISSUE aborts the transaction.
        step();
        act[1] = 1'b1; arm(1);
        step();
        rst_v = 1'b0;
        step();
        rst_v = 1'b1; act[0] = 1'b1; arm(0);
        step();
        check_eq("abort_ack",    bus.o_ack,  '0);
        check_eq("abort_strobe", {bus.o_rd, bus.o_wr}, 2'b00);
        check_eq("abort_busy",   bus.o_busy, 1'b0);
        step();
        check_eq("abort_next_strobe", bus.o_rd | bus.o_wr, 1'b1);
        step();
        check_eq("abort_next_ack", bus.o_ack, 3'b001);
        act = '0;
        step();

        // All three requesters, then without requester 0.
        rst_v = 1'b0; step(); step(); rst_v = 1'b1;
        clear_logs();
        act = '1; for (int k = 0; k < NREQ; k++) arm(k);
        for (int n = 0; n < 18; n++) begin
            step();
            react('1);
        end
`ifdef REGBUS_ARB_PRIO_EN
        check_grants("all_grant", '{0, 0, 0, 0, 0, 0});
`else
        check_grants("all_grant", '{0, 1, 2, 0, 1, 2});
`endif
        clear_logs();
        act[0] = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            react(3'b110);
        end
        act = '0;
        check_grants("no0_grant", '{1, 2, 1, 2});
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 700; n++) begin
            for (int k = 0; k < NREQ; k++) keep[k] = ($urandom_range(0, 3) == 0);
            react(keep);
            for (int k = 0; k < NREQ; k++) begin
                if (!act[k] && ($urandom_range(0, 3) == 0)) begin
                    act[k] = 1'b1;
                    arm(k);
                end
            end
            rst_v = ($urandom_range(0, 199) != 0);
            step();
        end
        act = '0; rst_v = 1'b1;
        for (int n = 0; n < 4; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
- Shares one simple register-bus target between NREQ requesters. The target is an axi_registers-style port: rreg/wreg index, rd/wr strobes, wdata out, combinational rdata in.
- Typical use: software via the AXI slave and an on-chip sequencer or debug engine both access the same control/debug register block.
- Arbitration is round-robin by default. Each transaction is a single non-pipelined read or write, completed with a one-cycle ack.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 2, register index width
- DW, 32, data width

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  NREQ  per-requester request level
- i_we  in  NREQ  per-requester, 1=write, 0=read
- i_addr  in  NREQ*AW  packed register indices, requester k at [k*AW +: AW]
- i_wdata  in  NREQ*DW  packed write data, requester k at [k*DW +: DW]
- o_ack  out  NREQ  one-hot completion pulse
- o_rdata  out  DW  read data, valid in the ack cycle of a read
- o_busy  out  1  high in ISSUE and RESP
- o_rreg  out  AW  target read index
- o_wreg  out  AW  target write index
- o_rd  out  1  target read strobe
- o_wr  out  1  target write strobe
- o_wdata  out  DW  target write data
- i_rdata  in  DW  target read data, combinational on o_rreg

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; last-grant pointer=NREQ-1, so requester 0 wins first.
- Reset asserted mid-transaction aborts it: no ack, no target strobe in the following cycle.

State machine:
- IDLE:
  - If any i_req, pick a winner by round-robin: search starts at last_grant+1 mod NREQ.
  - Latch winner index, we, addr, wdata; update last_grant; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly one cycle):
  - Write: o_wr=1, o_wreg=addr, o_wdata=data.
  - Read: o_rd=1, o_rreg=addr; i_rdata is sampled into the rdata register at the end of this cycle.
  - Go to RESP.
- RESP (exactly one cycle):
  - o_ack[winner]=1.
  - For a read, o_rdata holds the captured value; it stays held until the next read completes.
  - Go to IDLE.

Timing and handshake:
- Strobes are registered outputs.
- i_req is sampled only in IDLE.
- Latency: i_req high in IDLE cycle T gives the strobe in T+1 and ack in T+2.
- Peak throughput is one transaction per 3 cycles.
- Requester holds req/we/addr/wdata stable until it sees ack, then drops req at that same edge.
- req still high in the IDLE cycle after ack is treated as a new transaction (back-to-back is legal).
- Requester inputs change after latch and are ignored until the next IDLE.
- o_rd and o_wr are never high together.
- o_ack is at most one-hot and only high in RESP.
- Unused o_rreg/o_wreg/o_wdata hold their last values. Only the strobes qualify them.
- Round-robin pointer wraps NREQ-1 -> 0.
- A single persistent requester gets every slot. With all requesters asserting, grant order is 0,1,..,NREQ-1,0,...

Optional Feature:
- Macro REGBUS_ARB_PRIO_EN.
- Defined: requester 0 has fixed highest priority. It wins whenever i_req[0] is high in IDLE; the others share round-robin among themselves when req0 is low. The pointer is not updated by grants to requester 0.
- Undefined: pure round-robin as above.

Decomposition:
- Package regbus_pkg:
  - state enum typedef {IDLE, ISSUE, RESP}
  - default AW/DW localparams
  - function for the next round-robin index
- Sub-module rr_picker: combinational NREQ-wide round-robin priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: valid, winner index.
  - Also used for the non-zero group under REGBUS_ARB_PRIO_EN.

Test Plan:
- Reset then a single write: req0, we=1, addr=2, wdata=0xDEADBEEF at T. Expect o_wr=1, o_wreg=2, o_wdata=0xDEADBEEF at T+1; o_ack=01 at T+2.
- Read: req1, we=0, addr=3, target returns 0x12345678 for index 3. Expect o_rd=1 at T+1; o_ack=10 and o_rdata=0x12345678 at T+2.
- Contention: req0 and req1 held high continuously, NREQ=2. Expect grants 0,1,0,1, with acks every 3 cycles and no strobe overlap.
- Back-to-back: req0 held high across its ack. Expect a second transaction starting in the next IDLE cycle, strobe 3 cycles after the first.
- Reset mid-op: rst_n=0 during ISSUE. Expect no ack, all outputs 0 next cycle; after release, req0 wins first.
- REGBUS_ARB_PRIO_EN defined, NREQ=3, all requests high: expect every grant to go to 0. After req0 drops, expect grants alternating 1,2.
